lfsr_stream_checker: RTL and testbench

Receive-side companion to the 32-bit LFSR pattern generator: consumes a stream of 32-bit words, self-synchronises to the LFSR sequence, and flags and counts mismatches. It sits on the design's test/data path behind the generator or a loopback path. Status and counters are read back through the CSR space over UDM.

---
 rtl/lfsr_stream_checker.sv | 85 ++++++++
 tb/tb_lfsr_stream_checker.sv | 121 ++++++++++++
 2 files changed

// File: rtl/lfsr_stream_checker.sv
// lfsr_stream_checker: self-synchronising checker for the x^32+x^22+x^2+x+1 LFSR word stream
module lfsr_stream_checker #(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [31:0]      word_cnt,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;
  state_t state, state_n;
  logic [31:0] exp_w, exp_n;
  logic [MW-1:0] match_cnt, match_n;
  logic [LW-1:0] miss_cnt, miss_n;
  logic beat, bad;
  function automatic logic [31:0] nxt(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction
  assign locked = state == LOCKED;
  // next-state: seed/reseed while hunting or syncing, flywheel once locked
  always_comb begin
    state_n = state;
    exp_n = exp_w;
    match_n = match_cnt;
    miss_n = miss_cnt;
    beat = 1'b0;
    bad = 1'b0;
    if (in_valid)
      case (state)
        HUNT: if (in_data != 32'd0) begin
          exp_n = nxt(in_data);
          match_n = '0;
          state_n = SYNC;
        end
        SYNC: if (in_data == exp_w) begin
          exp_n = nxt(in_data);
          match_n = match_cnt + MW'(1);
          if (match_n == MW'(LOCK_CNT)) begin
            state_n = LOCKED;
            miss_n = '0;
          end
        end else if (in_data != 32'd0) begin
          exp_n = nxt(in_data);
          match_n = '0;
        end else state_n = HUNT;
        LOCKED: begin
          beat = 1'b1;
          exp_n = nxt(exp_w);
          bad = in_data != exp_w;
          miss_n = bad ? miss_cnt + LW'(1) : '0;
          state_n = bad && miss_n == LW'(LOSS_CNT) ? HUNT : LOCKED;
        end
        default: state_n = HUNT;
      endcase
  end
  // state, expectation and counters; clr wins over a simultaneous increment
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= HUNT;
      exp_w <= '0;
      match_cnt <= '0;
      miss_cnt <= '0;
      err_pulse <= 1'b0;
      word_cnt <= '0;
      err_cnt <= '0;
    end else begin
      state <= state_n;
      exp_w <= exp_n;
      match_cnt <= match_n;
      miss_cnt <= miss_n;
      err_pulse <= bad;
      word_cnt <= clr ? '0 : word_cnt + 32'(beat);
      err_cnt <= clr ? '0 : bad && ~&err_cnt ? err_cnt + ERR_W'(1) : err_cnt;
    end
  end
endmodule

// File: tb/tb_lfsr_stream_checker.sv
// tb_lfsr_stream_checker: directed stimulus with a queued-expectation scoreboard
module tb_lfsr_stream_checker;
  logic clk, rst_n, in_valid, clr, locked, err_pulse;
  logic [31:0] in_data, word_cnt, g;
  logic [3:0] err_cnt;
  int tests = 0, fails = 0;
  typedef struct {logic l; logic p; logic [31:0] wc; logic [3:0] ec; string nm;} exp_t;
  exp_t q[$];

  lfsr_stream_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .word_cnt(word_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] nxt(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  task automatic step(input logic r, input logic v, input logic [31:0] d, input logic c,
                      input logic l, input logic p, input int wc, input int ec, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n = r; in_valid = v; in_data = d; clr = c;
    e.l = l; e.p = p; e.wc = wc; e.ec = ec[3:0]; e.nm = nm;
    q.push_back(e);
  endtask

  task automatic good(input logic l, input int wc, input int ec, input string nm);
    step(1'b1, 1'b1, g, 1'b0, l, 1'b0, wc, ec, nm);
    g = nxt(g);
  endtask

  task automatic bad(input logic [31:0] x, input logic l, input int wc, input int ec, input string nm);
    step(1'b1, 1'b1, g ^ x, 1'b0, l, 1'b1, wc, ec, nm);
    g = nxt(g);
  endtask

  // monitor: outputs settle after each rising edge; compare against the oldest expectation
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      tests++;
      if (locked !== e.l || err_pulse !== e.p || word_cnt !== e.wc || err_cnt !== e.ec) begin
        fails++;
        $display("FAIL %s: got locked=%0b err_pulse=%0b word_cnt=%0d err_cnt=%0d, want locked=%0b err_pulse=%0b word_cnt=%0d err_cnt=%0d",
                 e.nm, locked, err_pulse, word_cnt, err_cnt, e.l, e.p, e.wc, e.ec);
      end
    end
  end

  initial begin
    int e, w;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; clr = 1'b0; g = '0;
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 0, 0, "reset0");
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 0, 0, "reset1");
    // lock acquisition: seed + 4 matches
    step(1'b1, 1'b1, 32'h1234FADC, 1'b0, 1'b0, 1'b0, 0, 0, "seed");
    step(1'b1, 1'b1, 32'h2469F5B9, 1'b0, 1'b0, 1'b0, 0, 0, "match1");
    g = nxt(32'h2469F5B9);
    good(1'b0, 0, 0, "match2");
    good(1'b0, 0, 0, "match3");
    good(1'b1, 0, 0, "lock");
    // single corrupted word costs exactly one error
    good(1'b1, 1, 0, "locked_beat");
    bad(32'h1, 1'b1, 2, 1, "single_err");
    good(1'b1, 3, 1, "resume1");
    good(1'b1, 4, 1, "resume2");
    good(1'b1, 5, 1, "resume3");
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 5, 1, "idle");
    // loss of lock and relock
    bad(32'hFFFF0000, 1'b1, 6, 2, "miss1");
    bad(32'hFFFF0000, 1'b1, 7, 3, "miss2");
    bad(32'hFFFF0000, 1'b0, 8, 4, "loss");
    good(1'b0, 8, 4, "reseed");
    good(1'b0, 8, 4, "relock_m1");
    good(1'b0, 8, 4, "relock_m2");
    good(1'b0, 8, 4, "relock_m3");
    good(1'b1, 8, 4, "relock");
    good(1'b1, 9, 4, "relocked_beat");
    // reset mid-stream while locked with nonzero counters
    step(1'b0, 1'b1, g, 1'b0, 1'b0, 1'b0, 0, 0, "mid_reset");
    // zeros in HUNT never seed
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 0, 0, "zero_in_hunt");
    step(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 0, 0, "seed_deadbeef");
    step(1'b1, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0, 0, 0, "reseed_one");
    g = nxt(32'h00000001);
    good(1'b0, 0, 0, "one_m1");
    good(1'b0, 0, 0, "one_m2");
    good(1'b0, 0, 0, "one_m3");
    good(1'b1, 0, 0, "one_lock");
    // saturation of the 4-bit error counter over repeated loss/relock
    e = 0; w = 0;
    for (int k = 0; k < 6; k++) begin
      for (int j = 0; j < 3; j++) begin
        e++; w++;
        bad(32'hFFFF0000, j < 2, w, e > 15 ? 15 : e, "sat_miss");
      end
      for (int j = 0; j < 4; j++) good(1'b0, w, e > 15 ? 15 : e, "sat_sync");
      good(1'b1, w, e > 15 ? 15 : e, "sat_relock");
    end
    bad(32'hFFFF0000, 1'b1, 19, 15, "sat_19");
    bad(32'hFFFF0000, 1'b1, 20, 15, "sat_20");
    // clr beats the increment; the mismatch still pulses and drops lock
    step(1'b1, 1'b1, g ^ 32'hFFFF0000, 1'b1, 1'b0, 1'b1, 0, 0, "clr_vs_miss");
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 0, 0, "after_clr");
    repeat (3) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
